mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MAX_WAIT, default 15, maximum BUSY cycles to wait for mem_data_valid before abandoning the access.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 EXMEMalu_out  in  16  memory address for loads and stores; ALU result for writeback otherwise.
REQ-005 EXMEMwrite_data  in  16  store data.
REQ-006 EXMEMpc  in  16  PC value written back for PCS.
REQ-007 EXMEMrd  in  4  destination register.
REQ-008 EXMEMMemRead, EXMEMMemWrite, EXMEMMemtoReg, EXMEMRegWrite, EXMEMLB, EXMEMPCS, EXMEMHLT  in  1 each  control bits from EX/MEM.
REQ-009 mem_addr, mem_wdata  out  16 each  data-memory request address and write data.
REQ-010 mem_en, mem_wr  out  1 each  one-cycle request strobe; mem_wr=1 marks a write.
REQ-011 mem_rdata  in  16  read data, meaningful only while mem_data_valid=1.
REQ-012 mem_data_valid  in  1  memory completion pulse for reads and writes.
REQ-013 stall  out  1  combinational; 1 freezes PC, IF/ID, ID/EX and EX/MEM (their WriteEnable = ~stall).
REQ-014 MEMWBwb_data  out  16  registered writeback value.
REQ-015 MEMWBrd  out  4  registered destination register.
REQ-016 MEMWBRegWrite, MEMWBHLT  out  1 each  registered control bits.
REQ-017 mem_err  out  1  sticky timeout flag.

Function
REQ-018 A memory op is EXMEMMemRead|EXMEMMemWrite; if both bits are 1, the op is a write.
REQ-019 FSM states: IDLE, BUSY.
REQ-020 IDLE with a memory op: in that cycle mem_en=1, mem_addr=EXMEMalu_out, mem_wdata=EXMEMwrite_data, mem_wr=op-is-write, stall=1; next state BUSY.
REQ-021 IDLE with no memory op: mem_en=0, stall=0, state stays IDLE, MEM/WB loads the instruction at the next edge (1-cycle latency).
REQ-022 In BUSY, mem_en=0 and stall=1 while mem_data_valid=0; a wait counter increments each BUSY cycle.
REQ-023 BUSY with mem_data_valid=1: stall=0, MEM/WB loads the instruction with the read data, next state IDLE, counter cleared.
REQ-024 BUSY with the counter at MAX_WAIT-1 and mem_data_valid=0: mem_err set, stall=0, MEM/WB loads a bubble, next state IDLE.
REQ-025 Every edge with stall=1 loads a bubble into MEM/WB: MEMWBRegWrite=0, MEMWBHLT=0, MEMWBrd=0, MEMWBwb_data=0.
REQ-026 Writeback select: EXMEMPCS gives EXMEMpc; otherwise EXMEMMemtoReg gives load data; otherwise EXMEMalu_out.
REQ-027 Load data: with EXMEMLB=0 it is mem_rdata; with EXMEMLB=1 it is the zero-extended byte mem_rdata[7:0] if EXMEMalu_out[0]=0, else mem_rdata[15:8].
REQ-028 A pass-through load or store writes MEMWBRegWrite=EXMEMRegWrite unmodified; stores are issued with EXMEMRegWrite=0 upstream.
REQ-029 mem_data_valid in IDLE is ignored: no state change and no capture.
REQ-030 mem_err stays 1 until rst.
REQ-031 A memory op is issued exactly once per EX/MEM instruction; the register advances only on the cycle stall=0.

Reset
REQ-032 rst=1 at an edge forces IDLE, counter=0, mem_err=0, and all MEMWB* outputs 0, regardless of state.
REQ-033 rst during BUSY abandons the access; a later mem_data_valid is ignored under REQ-029.
REQ-034 While rst=1, mem_en=0 and stall=0.

Verification
REQ-035 ALU op (alu_out=0x1234, rd=3, RegWrite=1, no mem op) -> stall=0; next edge MEMWBwb_data=0x1234, MEMWBrd=3, MEMWBRegWrite=1.
REQ-036 Load with addr=0x0040 and valid 3 cycles after issue, rdata=0xBEEF -> mem_en for 1 cycle, stall=1 for 3 cycles, MEMWB bubbles meanwhile, then MEMWBwb_data=0xBEEF.
REQ-037 LB with addr=0x0041, rdata=0xA5C3 -> MEMWBwb_data=0x00A5; with addr=0x0040 -> 0x00C3.
REQ-038 Store with MemRead=MemWrite=1, wdata=0x5555 -> mem_wr=1, mem_wdata=0x5555, MEMWBRegWrite=0 after completion.
REQ-039 Load with no valid and MAX_WAIT=15 -> stall for 15 cycles, mem_err=1, bubble written, IDLE; mem_err stays 1 through later traffic.
REQ-040 rst asserted during the 2nd BUSY cycle, then valid pulsed -> all outputs 0, no MEM/WB capture; PCS with pc=0x0022 -> MEMWBwb_data=0x0022.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage with a variable-latency data-memory port.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   EXMEM*                   instruction held in the EX/MEM register
//   mem_addr/mem_wdata       request address / store data
//   mem_en/mem_wr            one-cycle request strobe, mem_wr=1 marks a write
//   mem_rdata/mem_data_valid completion pulse (read data valid with it)
//   stall                    combinational; freezes PC, IF/ID, ID/EX, EX/MEM
//   MEMWB*                   registered writeback bundle
//   mem_err                  sticky timeout flag, cleared only by rst
//   dbg_state                FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a request is a single mem_en pulse issued from IDLE. The memory
// answers with one mem_data_valid pulse at any later cycle; the stage waits in
// BUSY holding stall=1 until that pulse or until MAX_WAIT BUSY cycles elapse.
// mem_data_valid seen while IDLE is not an answer to anything and is dropped.
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] EXMEMalu_out,
  input  logic [15:0] EXMEMwrite_data,
  input  logic [15:0] EXMEMpc,
  input  logic [3:0]  EXMEMrd,
  input  logic        EXMEMMemRead,
  input  logic        EXMEMMemWrite,
  input  logic        EXMEMMemtoReg,
  input  logic        EXMEMRegWrite,
  input  logic        EXMEMLB,
  input  logic        EXMEMPCS,
  input  logic        EXMEMHLT,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic        stall,
  output logic [15:0] MEMWBwb_data,
  output logic [3:0]  MEMWBrd,
  output logic        MEMWBRegWrite,
  output logic        MEMWBHLT,
  output logic        mem_err,
  output logic        dbg_state
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;
  logic [15:0]   wb_data_q, wb_data_d;
  logic [3:0]    wb_rd_q, wb_rd_d;
  logic          wb_rw_q, wb_rw_d;
  logic          wb_hlt_q, wb_hlt_d;

  logic          mem_op;
  logic          capture;
  logic [7:0]    byte_sel;
  logic [15:0]   load_data;
  logic [15:0]   wb_sel;

  always_comb begin
    mem_op    = EXMEMMemRead | EXMEMMemWrite;
    // Odd address selects the high byte of the halfword.
    byte_sel  = EXMEMalu_out[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    load_data = EXMEMLB ? {8'h00, byte_sel} : mem_rdata;
    if (EXMEMPCS)           wb_sel = EXMEMpc;
    else if (EXMEMMemtoReg) wb_sel = load_data;
    else                    wb_sel = EXMEMalu_out;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    mem_en     = 1'b0;
    stall      = 1'b0;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          mem_en     = 1'b1;
          stall      = 1'b1;
          state_d    = S_BUSY;
          wait_cnt_d = '0;
        end else begin
          capture = 1'b1;
        end
      end
      S_BUSY: begin
        if (mem_data_valid) begin
          capture    = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == LAST_WAIT) begin
          // Give up: release the pipeline and retire the access as a bubble.
          mem_err_d  = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      mem_en = 1'b0;
      stall  = 1'b0;
    end
    // Anything not captured (stall cycles, timeout) enters MEM/WB as a bubble.
    wb_data_d = capture ? wb_sel        : 16'h0000;
    wb_rd_d   = capture ? EXMEMrd       : 4'h0;
    wb_rw_d   = capture & EXMEMRegWrite;
    wb_hlt_d  = capture & EXMEMHLT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_hlt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_hlt_q   <= wb_hlt_d;
    end
  end

  assign mem_addr      = EXMEMalu_out;
  assign mem_wdata     = EXMEMwrite_data;
  assign mem_wr        = mem_en & EXMEMMemWrite;
  assign MEMWBwb_data  = wb_data_q;
  assign MEMWBrd       = wb_rd_q;
  assign MEMWBRegWrite = wb_rw_q;
  assign MEMWBHLT      = wb_hlt_q;
  assign mem_err       = mem_err_q;
  assign dbg_state     = state_q;

endmodule
